// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin among EXU/LSU/CSR write requests,
// a one-cycle registered write port, and a per-register pending-write scoreboard.
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                req_valid,
    output logic [2:0]                req_ready,
    input  logic [3*ADDR_WIDTH-1:0]   req_waddr,
    input  logic [3*DATA_WIDTH-1:0]   req_wdata,
    input  logic                      sb_set,
    input  logic [ADDR_WIDTH-1:0]     sb_addr,
    input  logic                      flush,
    input  logic [ADDR_WIDTH-1:0]     raddr1,
    output logic                      raddr1_busy,
    output logic                      rf_wen,
    output logic [ADDR_WIDTH-1:0]     rf_waddr,
    output logic [DATA_WIDTH-1:0]     rf_wdata
);
    localparam int NREG = 1 << ADDR_WIDTH;

    // Handshake rule: requester i transfers on a rising edge when
    // req_valid[i] & req_ready[i]; ready never depends on the requester
    // holding its payload afterwards, since the payload is captured on that edge.
    logic [1:0]            last_q;
    logic [1:0]            grant_idx;
    logic [1:0]            cand;
    logic                  grant_any;
    logic                  hs;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NREG-1:0]       busy_q;
    logic [NREG-1:0]       busy_next;

    // Search starts one past the last granted requester and wraps 2 -> 0.
    always_comb begin
        grant_idx = 2'd0;
        grant_any = 1'b0;
        cand      = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cand = 2'((int'(last_q) + 1 + k) % 3);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = 3'b000;
        if (!rst && !flush && grant_any)
            req_ready[grant_idx] = 1'b1;
    end

    assign hs       = |req_ready;
    assign sel_addr = req_waddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];

    // A new pending mark wins over a retiring write to the same register.
    always_comb begin
        busy_next = busy_q;
        if (rf_wen)
            busy_next[rf_waddr] = 1'b0;
        if (sb_set && (sb_addr != '0))
            busy_next[sb_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            last_q   <= 2'd2;
            busy_q   <= '0;
        end else begin
            rf_wen <= hs && (sel_addr != '0);
            if (hs) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
                last_q   <= grant_idx;
            end
            if (flush)
                busy_q <= '0;
            else
                busy_q <= busy_next;
        end
    end

    assign raddr1_busy = busy_q[raddr1];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter, checked against a
// cycle-level behavioural model of grants, write-back and the pending scoreboard.
module tb_rf_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [2:0]      req_valid;
    logic [2:0]      req_ready;
    logic [3*AW-1:0] req_waddr;
    logic [3*DW-1:0] req_wdata;
    logic            sb_set;
    logic [AW-1:0]   sb_addr;
    logic            flush;
    logic [AW-1:0]   raddr1;
    logic            raddr1_busy;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;

    rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_waddr(req_waddr), .req_wdata(req_wdata), .sb_set(sb_set),
        .sb_addr(sb_addr), .flush(flush), .raddr1(raddr1),
        .raddr1_busy(raddr1_busy), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int                  n_vec = 0;
    int                  n_err = 0;
    int                  m_last;
    logic [31:0]         m_busy;
    logic [AW-1:0]       m_addr;
    logic [DW-1:0]       m_data;
    bit                  m_known = 0;
    logic [AW+DW-1:0]    exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check outputs, then advance the model past the edge.
    task automatic step(input logic r, input logic [2:0] v,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                        input logic s, input logic [AW-1:0] sa, input logic f,
                        input logic [AW-1:0] ra);
        logic [AW-1:0]    aa[3];
        logic [DW-1:0]    dd[3];
        logic [2:0]       exp_ready;
        logic [AW+DW-1:0] w;
        int               win;
        bit               wen_now;
        aa[0] = a0; aa[1] = a1; aa[2] = a2;
        dd[0] = d0; dd[1] = d1; dd[2] = d2;
        rst = r; req_valid = v; req_waddr = {a2, a1, a0}; req_wdata = {d2, d1, d0};
        sb_set = s; sb_addr = sa; flush = f; raddr1 = ra;
        #1;
        exp_ready = 3'b000;
        win = -1;
        if (!r && !f)
            for (int k = 1; k <= 3; k++)
                if (win < 0 && v[(m_last + k) % 3]) win = (m_last + k) % 3;
        if (win >= 0) exp_ready[win] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        wen_now = (exp_q.size() != 0);
        if (m_known) begin
            check("raddr1_busy", 64'(raddr1_busy), 64'((ra == 0) ? 1'b0 : m_busy[ra]));
            check("rf_wen", 64'(rf_wen), 64'(wen_now));
            check("rf_waddr", 64'(rf_waddr), 64'(m_addr));
            check("rf_wdata", 64'(rf_wdata), 64'(m_data));
            if (wen_now) begin
                w = exp_q.pop_front();
                check("rf_write", 64'({rf_waddr, rf_wdata}), 64'(w));
            end
        end
        if (r) begin
            m_busy = '0; m_last = 2; m_addr = '0; m_data = '0;
            exp_q.delete();
            m_known = 1;
        end else begin
            if (f) m_busy = '0;
            else begin
                if (wen_now) m_busy[m_addr] = 1'b0;
                if (s && sa != 0) m_busy[sa] = 1'b1;
            end
            if (win >= 0) begin
                m_last = win;
                m_addr = aa[win];
                m_data = dd[win];
                if (aa[win] != 0) exp_q.push_back({aa[win], dd[win]});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [AW-1:0] ra);
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, ra);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_waddr = '0; req_wdata = '0;
        sb_set = 1'b0; sb_addr = '0; flush = 1'b0; raddr1 = '0;

        step(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // all three requesting: grants 0,1,2 and writes x1,x2,x3
        for (int i = 0; i < 3; i++)
            step(0, 3'b111, 1, 2, 3, 32'h100, 32'h200, 32'h300, 0, 0, 0, 0);
        idle(0);
        idle(0);

        // pending x5 stays busy through its write-back cycle
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 5, 0, 5);
        step(0, 3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5);
        idle(5);
        idle(5);

        // LSU write to x0 handshakes but never writes
        step(0, 3'b010, 0, 0, 0, 0, 32'h1234, 0, 0, 0, 0, 5);
        idle(5);

        // set and clear of x7 on the same edge: set wins
        step(0, 3'b001, 7, 0, 0, 32'h77, 0, 0, 0, 0, 0, 7);
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 7, 0, 7);
        idle(7);

        // flush while EXU offers x9 with x9 pending
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
        step(0, 3'b001, 9, 0, 0, 32'h99, 0, 0, 0, 0, 1, 9);
        idle(9);
        idle(7);

        // reset mid-operation with LSU requesting and x4 pending
        step(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 4, 0, 4);
        step(0, 3'b010, 0, 4, 0, 0, 32'h44, 0, 0, 0, 0, 4);
        step(1, 3'b010, 0, 4, 0, 0, 32'h44, 0, 1, 6, 1, 4);
        step(0, 3'b011, 8, 4, 0, 32'h88, 32'h44, 0, 0, 0, 0, 4);
        idle(8);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(199) == 0), 3'($urandom),
                 AW'($urandom_range(7)), AW'($urandom_range(7)), AW'($urandom_range(7)),
                 $urandom, $urandom, $urandom,
                 ($urandom_range(2) == 0), AW'($urandom_range(7)),
                 ($urandom_range(19) == 0), AW'($urandom_range(7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
